eth_prbs_checker: RTL and testbench

//  Self-synchronising PRBS pattern checker for the 10G PHY datapath; replaces bench-side pass/fail checks with a reusable block.

---
 rtl/eth_prbs_pkg.sv | 37 +++
 rtl/eth_prbs_popcount.sv | 23 ++
 rtl/eth_prbs_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_eth_prbs_checker.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/eth_prbs_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : eth_prbs_pkg
//  Description : PRBS checker mode encodings, tap table and FSM state encoding.
//  Revision    : 1.0
// =============================================================================
package eth_prbs_pkg;

    localparam logic [1:0] c_mode_prbs7  = 2'd0;
    localparam logic [1:0] c_mode_prbs15 = 2'd1;
    localparam logic [1:0] c_mode_prbs23 = 2'd2;
    localparam logic [1:0] c_mode_prbs31 = 2'd3;

    localparam logic [1:0] c_st_disabled = 2'd0;
    localparam logic [1:0] c_st_fill     = 2'd1;
    localparam logic [1:0] c_st_unlocked = 2'd2;
    localparam logic [1:0] c_st_locked   = 2'd3;

    typedef struct packed {
        logic [4:0] n;
        logic [4:0] m;
    } prbs_taps_t;

    // Polynomial x^N + x^M + 1 for each selectable pattern
    function automatic prbs_taps_t prbs_taps(input logic [1:0] mode);
        prbs_taps_t t;
        case (mode)
            c_mode_prbs7:  t = '{n: 5'd7,  m: 5'd6};
            c_mode_prbs15: t = '{n: 5'd15, m: 5'd14};
            c_mode_prbs23: t = '{n: 5'd23, m: 5'd18};
            default:       t = '{n: 5'd31, m: 5'd28};
        endcase
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eth_prbs_popcount.sv
`default_nettype none
// =============================================================================
//  Module      : eth_prbs_popcount
//  Description : Combinational population count of an error vector.
//  Revision    : 1.0
// =============================================================================
module eth_prbs_popcount #(
    parameter int DATA_WIDTH = 64,
    parameter int POP_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [POP_WIDTH-1:0]  o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            o_count = o_count + POP_WIDTH'(i_data[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/eth_prbs_checker.sv
`default_nettype none
// =============================================================================
//  Module      : eth_prbs_checker
//  Description : Self-synchronising PRBS7/15/23/31 checker with lock FSM and
//                saturating bit/word error statistics.
//  Revision    : 1.0
// =============================================================================
module eth_prbs_checker
    import eth_prbs_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int INVERT        = 0,
    parameter int LOCK_COUNT    = 16,
    parameter int WINDOW        = 64,
    parameter int UNLOCK_ERRORS = 8,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_enable,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_clear,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  bit_err_count,
    output logic [CNT_WIDTH-1:0]  word_err_count,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int PW = $clog2(DATA_WIDTH + 1);
    localparam int SW = DATA_WIDTH + 31;
    localparam int IW = $clog2(SW);
    localparam int RW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(UNLOCK_ERRORS + 1);
    localparam int AW = ((CNT_WIDTH > PW) ? CNT_WIDTH : PW) + 1;
    localparam logic                 c_inv     = (INVERT != 0);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

    if (DATA_WIDTH < 32 || DATA_WIDTH > 64) begin : g_bad_width
        $error("eth_prbs_checker: DATA_WIDTH must be within 32..64");
    end
    if (UNLOCK_ERRORS < 1 || UNLOCK_ERRORS > WINDOW) begin : g_bad_unlock
        $error("eth_prbs_checker: UNLOCK_ERRORS must be within 1..WINDOW");
    end

    logic [30:0]           hist_q, hist_d;
    logic [1:0]            state_q, state_d;
    logic [1:0]            mode_q;
    logic [RW-1:0]         run_q, run_d;
    logic [WW-1:0]         win_q, win_d;
    logic [EW-1:0]         werr_q, werr_d;
    logic                  locked_q, locked_d;
    logic                  err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0]  bit_err_q, bit_err_d;
    logic [CNT_WIDTH-1:0]  word_err_q, word_err_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;

    logic [SW-1:0]         w_s;
    prbs_taps_t            w_taps;
    logic                  w_stuck;
    logic [DATA_WIDTH-1:0] w_err;
    logic [PW-1:0]         w_pop;
    logic                  w_word_err;
    logic                  w_count_en;
    logic [EW-1:0]         w_werr_next;
    logic [WW-1:0]         w_win_next;
    logic [AW-1:0]         w_bit_sum;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == c_cnt_max) ? v : v + CNT_WIDTH'(1);
    endfunction

    // A real PRBS never repeats one value for 32+ bits, so a uniform word is a
    // stuck line that the XOR check alone would accept as error-free.
    always_comb begin
        w_taps  = prbs_taps(cfg_mode);
        w_s     = {in_data, hist_q};
        w_stuck = (in_data == {DATA_WIDTH{c_inv}});
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_err[i] = w_s[31 + i]
                     ^ w_s[IW'(31 + i - int'(w_taps.n))]
                     ^ w_s[IW'(31 + i - int'(w_taps.m))]
                     ^ c_inv;
        end
        if (w_stuck) begin
            w_err = '1;
        end
    end

    eth_prbs_popcount #(
        .DATA_WIDTH (DATA_WIDTH),
        .POP_WIDTH  (PW)
    ) u_popcount (
        .i_data  (w_err),
        .o_count (w_pop)
    );

    assign w_word_err = |w_err;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        run_d       = run_q;
        win_d       = win_q;
        werr_d      = werr_q;
        err_pulse_d = 1'b0;
        w_count_en  = 1'b0;
        w_werr_next = werr_q + EW'(w_word_err);
        w_win_next  = win_q + WW'(1);
        if (in_valid) begin
            hist_d = in_data[DATA_WIDTH-1 -: 31];
        end
        if (!cfg_enable) begin
            state_d = c_st_disabled;
            run_d   = '0;
            win_d   = '0;
            werr_d  = '0;
        end else if (state_q == c_st_disabled || cfg_mode != mode_q) begin
            state_d = c_st_fill;
            run_d   = '0;
            win_d   = '0;
            werr_d  = '0;
        end else if (in_valid) begin
            case (state_q)
                c_st_fill: begin
                    state_d = c_st_unlocked;
                    run_d   = '0;
                end
                c_st_unlocked: begin
                    if (w_word_err) begin
                        run_d = '0;
                    end else if (run_q == RW'(LOCK_COUNT - 1)) begin
                        state_d = c_st_locked;
                        run_d   = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else begin
                        run_d = run_q + RW'(1);
                    end
                end
                c_st_locked: begin
                    w_count_en  = 1'b1;
                    err_pulse_d = w_word_err;
                    if (w_werr_next == EW'(UNLOCK_ERRORS)) begin
                        state_d = c_st_unlocked;
                        run_d   = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (w_win_next == WW'(WINDOW)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d  = w_win_next;
                        werr_d = w_werr_next;
                    end
                end
                default: state_d = c_st_fill;
            endcase
        end
        locked_d = (state_d == c_st_locked);
    end

    always_comb begin
        bit_err_d  = bit_err_q;
        word_err_d = word_err_q;
        word_cnt_d = word_cnt_q;
        w_bit_sum  = AW'(bit_err_q) + AW'(w_pop);
        if (cfg_clear) begin
            bit_err_d  = '0;
            word_err_d = '0;
            word_cnt_d = '0;
        end else if (w_count_en) begin
            word_cnt_d = sat_inc(word_cnt_q);
            if (w_word_err) begin
                word_err_d = sat_inc(word_err_q);
            end
            bit_err_d = (w_bit_sum > AW'(c_cnt_max)) ? c_cnt_max : CNT_WIDTH'(w_bit_sum);
        end
    end

    // mode_q only detects mode changes, so it tracks cfg_mode even in reset
    // to avoid a spurious restart on the first cycle out of reset.
    always_ff @(posedge clk) begin
        mode_q <= cfg_mode;
        if (rst) begin
            state_q     <= c_st_fill;
            hist_q      <= '0;
            run_q       <= '0;
            win_q       <= '0;
            werr_q      <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            bit_err_q   <= '0;
            word_err_q  <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            run_q       <= run_d;
            win_q       <= win_d;
            werr_q      <= werr_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            bit_err_q   <= bit_err_d;
            word_err_q  <= word_err_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign locked         = locked_q;
    assign err_pulse      = err_pulse_q;
    assign bit_err_count  = bit_err_q;
    assign word_err_count = word_err_q;
    assign word_count     = word_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_prbs_checker.sv
`default_nettype none
// =============================================================================
//  Module      : tb_eth_prbs_checker
//  Description : Directed self-checking bench for eth_prbs_checker.
//  Revision    : 1.0
// =============================================================================
module tb_eth_prbs_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: default 64-bit, non-inverted, 32-bit counters
    logic        a_en = 1'b1, a_clear = 1'b0, a_valid = 1'b0;
    logic [1:0]  a_mode = 2'd3;
    logic [63:0] a_data = '0;
    logic        a_locked, a_pulse;
    logic [31:0] a_bit_err, a_word_err, a_word_cnt;

    // Instance B: 32-bit, inverted pattern, 4-bit counters
    logic        b_en = 1'b1, b_clear = 1'b0, b_valid = 1'b0;
    logic [1:0]  b_mode = 2'd2;
    logic [31:0] b_data = '0;
    logic        b_locked, b_pulse;
    logic [3:0]  b_bit_err, b_word_err, b_word_cnt;

    eth_prbs_checker u_dut_a (
        .clk(clk), .rst(rst), .cfg_enable(a_en), .cfg_mode(a_mode), .cfg_clear(a_clear),
        .in_data(a_data), .in_valid(a_valid), .locked(a_locked), .err_pulse(a_pulse),
        .bit_err_count(a_bit_err), .word_err_count(a_word_err), .word_count(a_word_cnt)
    );

    eth_prbs_checker #(.DATA_WIDTH(32), .INVERT(1), .CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .cfg_enable(b_en), .cfg_mode(b_mode), .cfg_clear(b_clear),
        .in_data(b_data), .in_valid(b_valid), .locked(b_locked), .err_pulse(b_pulse),
        .bit_err_count(b_bit_err), .word_err_count(b_word_err), .word_count(b_word_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [30:0] ga, gb;
    int          an = 31, am = 28;
    logic [63:0] w;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference PRBS source: b[n] = b[n-N] ^ b[n-M], h[30] is the newest bit
    task automatic gen_word(inout logic [30:0] h, input int n, input int m,
                            input int nbits, output logic [63:0] wd);
        logic nb;
        wd = '0;
        for (int i = 0; i < nbits; i++) begin
            nb    = h[5'(31 - n)] ^ h[5'(31 - m)];
            h     = {nb, h[30:1]};
            wd[i] = nb;
        end
    endtask

    task automatic a_word(input logic [63:0] d, input logic v);
        a_data  = d;
        a_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic a_prbs();
        gen_word(ga, an, am, 64, w);
        a_word(w, 1'b1);
    endtask

    task automatic b_word(input logic [31:0] d, input logic v);
        b_data  = d;
        b_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic b_prbs();
        gen_word(gb, 23, 18, 32, w);
        b_word(~w[31:0], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_locked", a_locked, 0);
        check_eq("reset_pulse", a_pulse, 0);
        check_eq("reset_bit_err", a_bit_err, 0);
        check_eq("reset_word_cnt", a_word_cnt, 0);
        rst = 1'b0;

        // Clean PRBS31: fill word + 16 clean words to lock
        ga = '1;
        for (int i = 0; i < 16; i++) a_prbs();
        check_eq("p31_not_locked_16", a_locked, 0);
        a_prbs();
        check_eq("p31_locked_17", a_locked, 1);
        check_eq("p31_word_cnt_at_lock", a_word_cnt, 0);
        for (int i = 0; i < 10; i++) a_prbs();
        check_eq("p31_word_cnt_10", a_word_cnt, 10);
        check_eq("p31_bit_err_clean", a_bit_err, 0);
        check_eq("p31_word_err_clean", a_word_err, 0);

        // Single flipped bit -> three counted bit errors
        gen_word(ga, an, am, 64, w);
        a_word(w ^ 64'h1, 1'b1);
        check_eq("flip_pulse", a_pulse, 1);
        check_eq("flip_bit_err", a_bit_err, 3);
        check_eq("flip_word_err", a_word_err, 1);
        check_eq("flip_locked", a_locked, 1);
        check_eq("flip_word_cnt", a_word_cnt, 11);
        a_prbs();
        check_eq("flip_pulse_clear", a_pulse, 0);
        check_eq("flip_bit_err_held", a_bit_err, 3);

        // Mode change to PRBS7: drop lock, stats held, relock after 17 words
        a_mode = 2'd0;
        a_word(64'hDEAD_BEEF_0123_4567, 1'b0);
        check_eq("mode_unlock", a_locked, 0);
        check_eq("mode_bit_err_held", a_bit_err, 3);
        check_eq("mode_word_cnt_held", a_word_cnt, 12);
        ga = '1; an = 7; am = 6;
        for (int i = 0; i < 16; i++) a_prbs();
        check_eq("p7_not_locked_16", a_locked, 0);
        a_prbs();
        check_eq("p7_locked_17", a_locked, 1);
        check_eq("p7_word_cnt_held", a_word_cnt, 12);

        // Clear, then all-zero words drop lock after 8 errored words
        a_clear = 1'b1;
        a_word(64'h0, 1'b0);
        a_clear = 1'b0;
        check_eq("clear_bit_err", a_bit_err, 0);
        check_eq("clear_word_cnt", a_word_cnt, 0);
        for (int i = 0; i < 7; i++) a_word(64'h0, 1'b1);
        check_eq("zero_locked_7", a_locked, 1);
        check_eq("zero_word_err_7", a_word_err, 7);
        a_word(64'h0, 1'b1);
        check_eq("zero_unlock_8", a_locked, 0);
        check_eq("zero_pulse_8", a_pulse, 1);
        check_eq("zero_bit_err_8", a_bit_err, 512);
        check_eq("zero_word_err_8", a_word_err, 8);
        check_eq("zero_word_cnt_8", a_word_cnt, 8);
        for (int i = 0; i < 20; i++) a_word(64'h0, 1'b1);
        check_eq("zero_never_relock", a_locked, 0);
        check_eq("zero_bit_err_held", a_bit_err, 512);

        // Reset mid-stream
        rst = 1'b1;
        a_word(64'h0, 1'b1);
        check_eq("midrst_bit_err", a_bit_err, 0);
        check_eq("midrst_word_err", a_word_err, 0);
        rst = 1'b0;
        a_word(64'h0, 1'b0);

        // Inverted PRBS23, 32-bit, gapped valid
        gb = '1;
        for (int i = 0; i < 16; i++) begin
            b_word($urandom, 1'b0);
            b_prbs();
        end
        check_eq("inv_not_locked_16", b_locked, 0);
        b_word($urandom, 1'b0);
        b_prbs();
        check_eq("inv_locked_17", b_locked, 1);
        check_eq("inv_bit_err", b_bit_err, 0);
        for (int i = 0; i < 20; i++) b_prbs();
        check_eq("inv_word_cnt_sat", b_word_cnt, 15);
        check_eq("inv_word_err_clean", b_word_err, 0);

        // Stuck-at-one words saturate the 4-bit bit counter
        b_word(32'hFFFF_FFFF, 1'b1);
        check_eq("sat_bit_err_1", b_bit_err, 15);
        check_eq("sat_word_err_1", b_word_err, 1);
        check_eq("sat_pulse", b_pulse, 1);
        b_word(32'hFFFF_FFFF, 1'b1);
        check_eq("sat_bit_err_2", b_bit_err, 15);
        check_eq("sat_word_err_2", b_word_err, 2);
        check_eq("sat_locked", b_locked, 1);
        b_clear = 1'b1;
        b_word(32'hFFFF_FFFF, 1'b1);
        b_clear = 1'b0;
        check_eq("clr_win_bit_err", b_bit_err, 0);
        check_eq("clr_win_word_err", b_word_err, 0);
        check_eq("clr_win_word_cnt", b_word_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
